// File: rtl/mdu_iter_if.sv
// Handshake and operand/result bundle between the EXE stage controller and mdu_iter.
// master drives the instruction side, slave (the MDU) returns busy/done and HI/LO.
interface mdu_iter_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ex_advance_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, ex_advance_i, cancel_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, ex_advance_i, cancel_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU: MUL_CYCLES busy cycles per multiply, start + 32 cycles per divide; MDU_EARLY_TERM_EN adds the |a|<|b| divide shortcut.
// busy_o stalls the pipe while computing; results sit in DONE (busy_o low) until ex_advance_i or cancel_i.
module mdu_iter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic      clk,
  input  logic      resetn,
  mdu_iter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        mul_sgn_q, mul_sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic        in_signed, a_neg, b_neg, early, mul_s;
  logic [31:0] a_mag, b_mag, mul_a, mul_b, quo_nx, rem_nx;
  logic [63:0] prod;
  logic [32:0] rem_sh, diff;

  assign in_signed = ~bus.op_i[0];
  assign a_neg     = in_signed & bus.a_i[31];
  assign b_neg     = in_signed & bus.b_i[31];
  assign a_mag     = a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
  assign b_mag     = b_neg ? (~bus.b_i + 32'd1) : bus.b_i;

`ifdef MDU_EARLY_TERM_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One multiplier shared between the direct IDLE path (MUL_CYCLES==1) and MUL state.
  assign mul_s = (state_q == S_IDLE) ? in_signed : mul_sgn_q;
  assign mul_a = (state_q == S_IDLE) ? bus.a_i   : opa_q;
  assign mul_b = (state_q == S_IDLE) ? bus.b_i   : opb_q;
  assign prod  = {{32{mul_s & mul_a[31]}}, mul_a} * {{32{mul_s & mul_b[31]}}, mul_b};

  // Restoring step: opa_q shifts dividend bits out and quotient bits in.
  assign rem_sh = {rem_q, opa_q[31]};
  assign diff   = rem_sh - {1'b0, opb_q};
  assign quo_nx = {opa_q[30:0], ~diff[32]};
  assign rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_sgn_d = mul_sgn_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    if (bus.cancel_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (!bus.op_i[1]) begin
              mul_sgn_d = in_signed;
              opa_d     = bus.a_i;
              opb_d     = bus.b_i;
              cnt_d     = 5'(MUL_CYCLES - 1);
              if (MUL_CYCLES <= 1) begin
                hi_d    = prod[63:32];
                lo_d    = prod[31:0];
                state_d = S_DONE;
              end else begin
                state_d = S_MUL;
              end
            end else if (bus.b_i == 32'd0) begin
              hi_d    = bus.a_i;
              lo_d    = 32'hFFFF_FFFF;
              state_d = S_DONE;
            end else if (early) begin
              hi_d    = bus.a_i;
              lo_d    = 32'd0;
              state_d = S_DONE;
            end else begin
              opa_d   = a_mag;
              opb_d   = b_mag;
              rem_d   = 32'd0;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = 5'd31;
              state_d = S_DIV;
            end
          end
        end
        // The start cycle counts as the first multiplier cycle.
        S_MUL: begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          opa_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            lo_d    = qneg_q ? (~quo_nx + 32'd1) : quo_nx;
            hi_d    = rneg_q ? (~rem_nx + 32'd1) : rem_nx;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.ex_advance_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      rem_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mul_sgn_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_sgn_q <= mul_sgn_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
    end
  end

  assign bus.busy_o = bus.start_i & ~bus.cancel_i & (state_q != S_DONE);
  assign bus.done_o = (state_q == S_DONE);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule
